// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the writeback stage shares the port with a small MDU result FIFO.
// Starved FIFO heads force a one-cycle writeback stall. A busy scoreboard tracks MDU destinations still outstanding.
module rf_write_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_sel_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_stall_o,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_sel_rd_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  output logic [31:0] busy_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_sel_rd_o,
  output logic [31:0] rf_data_o
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_WB,
    GNT_DRAIN,
    GNT_FORCE
  } grant_e;

  logic [4:0]  fifo_rd_mem   [FIFO_DEPTH];
  logic [31:0] fifo_data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       busy_q, busy_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_sel_rd_q, rf_sel_rd_d;
  logic [31:0]       rf_data_q, rf_data_d;

  grant_e      grant;
  logic        fifo_ne;
  logic        enq;
  logic        deq;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign fifo_ne     = (count_q != '0);
  assign mdu_ready_o = (count_q < CNT_W'(FIFO_DEPTH));
  assign enq         = mdu_valid_i && mdu_ready_o;
  assign head_rd     = fifo_rd_mem[rd_ptr_q];
  assign head_data   = fifo_data_mem[rd_ptr_q];

  // Grant depends only on registered FIFO state plus the live writeback request.
  always_comb begin
    grant = GNT_IDLE;
    if (fifo_ne && (wait_q == WAIT_W'(MAX_WAIT))) begin
      grant = GNT_FORCE;
    end else if (wb_we_i) begin
      grant = GNT_WB;
    end else if (fifo_ne) begin
      grant = GNT_DRAIN;
    end
  end

  assign deq        = (grant == GNT_FORCE) || (grant == GNT_DRAIN);
  assign wb_stall_o = (grant == GNT_FORCE) && wb_we_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    rf_we_d     = 1'b0;
    rf_sel_rd_d = rf_sel_rd_q;
    rf_data_d   = rf_data_q;

    if (enq) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

    if (deq || !fifo_ne) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // Clear before set so a same-cycle issue to the draining rd stays busy.
    if (deq) begin
      busy_d[head_rd] = 1'b0;
    end
    if (issue_i && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (deq) begin
      rf_we_d     = (head_rd != 5'd0);
      rf_sel_rd_d = head_rd;
      rf_data_d   = head_data;
    end else if (grant == GNT_WB) begin
      rf_we_d     = (wb_sel_rd_i != 5'd0);
      rf_sel_rd_d = wb_sel_rd_i;
      rf_data_d   = wb_data_i;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd_mem[wr_ptr_q]   <= mdu_sel_rd_i;
      fifo_data_mem[wr_ptr_q] <= mdu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      busy_q      <= '0;
      rf_we_q     <= 1'b0;
      rf_sel_rd_q <= 5'd0;
      rf_data_q   <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      rf_we_q     <= rf_we_d;
      rf_sel_rd_q <= rf_sel_rd_d;
      rf_data_q   <= rf_data_d;
    end
  end

  assign busy_o      = busy_q;
  assign rf_we_o     = rf_we_q;
  assign rf_sel_rd_o = rf_sel_rd_q;
  assign rf_data_o   = rf_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected register-file writes are queued at stimulus time
// and matched against every rf_we_o pulse; control outputs are checked against cycle-exact expectations.
module tb_rf_write_arbiter;

  localparam int FIFO_DEPTH = 2;
  localparam int MAX_WAIT   = 4;

  logic        clk;
  logic        rst_n;
  logic        wb_we_i;
  logic [4:0]  wb_sel_rd_i;
  logic [31:0] wb_data_i;
  logic        wb_stall_o;
  logic        mdu_valid_i;
  logic [4:0]  mdu_sel_rd_i;
  logic [31:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] busy_o;
  logic        rf_we_o;
  logic [4:0]  rf_sel_rd_o;
  logic [31:0] rf_data_o;

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [36:0] exp_q[$];

  rf_write_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_we_i     (wb_we_i),
    .wb_sel_rd_i (wb_sel_rd_i),
    .wb_data_i   (wb_data_i),
    .wb_stall_o  (wb_stall_o),
    .mdu_valid_i (mdu_valid_i),
    .mdu_sel_rd_i(mdu_sel_rd_i),
    .mdu_data_i  (mdu_data_i),
    .mdu_ready_o (mdu_ready_o),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .busy_o      (busy_o),
    .rf_we_o     (rf_we_o),
    .rf_sel_rd_o (rf_sel_rd_o),
    .rf_data_o   (rf_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && rf_we_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rf_write", 64'({rf_sel_rd_o, rf_data_o}), 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("rf_write", 64'({rf_sel_rd_o, rf_data_o}), 64'(e));
        $display("rf write rd=%0d data=%08h (expected rd=%0d data=%08h)",
                 rf_sel_rd_o, rf_data_o, e[36:32], e[31:0]);
      end
    end
  end

  initial begin
    int idx;
    int m;
    logic stall_exp;
    logic rdy_exp;

    rst_n = 1'b0;
    wb_we_i = 1'b0; wb_sel_rd_i = '0; wb_data_i = '0;
    mdu_valid_i = 1'b0; mdu_sel_rd_i = '0; mdu_data_i = '0;
    issue_i = 1'b0; issue_rd_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rf_we", 64'(rf_we_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ready", 64'(mdu_ready_o), 64'd1);
    check("rst_stall", 64'(wb_stall_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Writeback only, then an x0 write that must be suppressed
    wb_we_i = 1'b1; wb_sel_rd_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clk);
    check("wb_stall", 64'(wb_stall_o), 64'd0);
    tick();
    wb_sel_rd_i = 5'd0; wb_data_i = 32'h0BAD0BAD;
    tick();
    wb_we_i = 1'b0;
    @(negedge clk);
    check("wb_x0_we", 64'(rf_we_o), 64'd0);
    tick();

    // MDU issue and drain
    issue_i = 1'b1; issue_rd_i = 5'd7;
    tick();
    issue_i = 1'b0;
    mdu_valid_i = 1'b1; mdu_sel_rd_i = 5'd7; mdu_data_i = 32'h12345678;
    exp_q.push_back({5'd7, 32'h12345678});
    @(negedge clk);
    check("drain_busy_set", 64'(busy_o[7]), 64'd1);
    check("drain_ready", 64'(mdu_ready_o), 64'd1);
    tick();
    mdu_valid_i = 1'b0;
    @(negedge clk);
    check("drain_no_early_we", 64'(rf_we_o), 64'd0);
    tick();
    @(negedge clk);
    check("drain_busy_clr", 64'(busy_o[7]), 64'd0);
    tick();

    // Starvation: continuous writeback with one queued MDU result
    idx = 0;
    wb_we_i = 1'b1; wb_sel_rd_i = 5'd3;
    for (int c = 0; c <= MAX_WAIT + 2; c++) begin
      wb_data_i = 32'hA0000000 + 32'(idx);
      mdu_valid_i = (c == 0);
      mdu_sel_rd_i = 5'd10; mdu_data_i = 32'hB0B0B0B0;
      stall_exp = (c == MAX_WAIT + 1);
      if (stall_exp) begin
        exp_q.push_back({5'd10, 32'hB0B0B0B0});
      end else begin
        exp_q.push_back({5'd3, 32'hA0000000 + 32'(idx)});
        idx++;
      end
      @(negedge clk);
      if (c == 0) check("starve_ready", 64'(mdu_ready_o), 64'd1);
      check($sformatf("starve_stall_c%0d", c), 64'(wb_stall_o), 64'(stall_exp));
      tick();
    end
    wb_we_i = 1'b0; mdu_valid_i = 1'b0;
    repeat (3) tick();

    // Backpressure: FIFO fills while writeback holds the port
    idx = 0; m = 0;
    wb_we_i = 1'b1; wb_sel_rd_i = 5'd4;
    for (int c = 0; c <= MAX_WAIT + 2; c++) begin
      wb_data_i = 32'hC0000000 + 32'(idx);
      mdu_valid_i = 1'b1;
      mdu_sel_rd_i = 5'd11 + 5'(m);
      mdu_data_i = 32'hD0000000 + 32'(m);
      stall_exp = (c == MAX_WAIT + 1);
      rdy_exp = (c < 2) || (c == MAX_WAIT + 2);
      if (stall_exp) begin
        exp_q.push_back({5'd11, 32'hD0000000});
      end else begin
        exp_q.push_back({5'd4, 32'hC0000000 + 32'(idx)});
        idx++;
      end
      @(negedge clk);
      check($sformatf("bp_stall_c%0d", c), 64'(wb_stall_o), 64'(stall_exp));
      check($sformatf("bp_ready_c%0d", c), 64'(mdu_ready_o), 64'(rdy_exp));
      if (rdy_exp) m++;
      tick();
    end
    wb_we_i = 1'b0; mdu_valid_i = 1'b0;
    exp_q.push_back({5'd12, 32'hD0000001});
    exp_q.push_back({5'd13, 32'hD0000002});
    repeat (4) tick();
    @(negedge clk);
    check("bp_ready_after", 64'(mdu_ready_o), 64'd1);
    tick();

    // Scoreboard race: re-issue of rd 9 while its old result dequeues
    issue_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    issue_i = 1'b0;
    mdu_valid_i = 1'b1; mdu_sel_rd_i = 5'd9; mdu_data_i = 32'h99990009;
    exp_q.push_back({5'd9, 32'h99990009});
    tick();
    mdu_valid_i = 1'b0;
    issue_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    issue_i = 1'b0;
    @(negedge clk);
    check("race_busy9", 64'(busy_o[9]), 64'd1);
    tick();

    // Reset in the middle of traffic
    wb_we_i = 1'b1; wb_sel_rd_i = 5'd6; wb_data_i = 32'hE6E6E6E6;
    mdu_valid_i = 1'b1; mdu_sel_rd_i = 5'd13; mdu_data_i = 32'h13131313;
    issue_i = 1'b1; issue_rd_i = 5'd14;
    exp_q.push_back({5'd6, 32'hE6E6E6E6});
    tick();
    wb_we_i = 1'b0; mdu_valid_i = 1'b0; issue_i = 1'b0;
    @(negedge clk);
    check("pre_rst_busy14", 64'(busy_o[14]), 64'd1);
    check("pre_rst_ready", 64'(mdu_ready_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_rf_we", 64'(rf_we_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_ready", 64'(mdu_ready_o), 64'd1);
    check("midrst_stall", 64'(wb_stall_o), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("postrst_ready", 64'(mdu_ready_o), 64'd1);
    check("postrst_busy", 64'(busy_o), 64'd0);
    tick();

    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained into the register file on cycles with no writeback write. A starvation counter forces the writeback stage to yield when needed. The block also keeps a scoreboard of destination registers with MDU results outstanding, which the decode stage uses for hazard stalls.

## Interface
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- MAX_WAIT, 4, max cycles a non-empty FIFO head waits before forcing a writeback stall (≥1)

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_we_i  input  1  writeback stage requests a register write this cycle
- wb_sel_rd_i  input  5  writeback destination register
- wb_data_i  input  32  writeback data
- wb_stall_o  output  1  writeback write not accepted this cycle; pipeline holds wb_* inputs
- mdu_valid_i  input  1  MDU result valid
- mdu_sel_rd_i  input  5  MDU destination register
- mdu_data_i  input  32  MDU result
- mdu_ready_o  output  1  FIFO can accept an MDU result
- issue_i  input  1  MDU operation issued this cycle
- issue_rd_i  input  5  destination of the issued MDU operation
- busy_o  output  32  scoreboard; bit n set = MDU result for xn outstanding
- rf_we_o  output  1  register-file write enable (registered)
- rf_sel_rd_o  output  5  register-file write address (registered)
- rf_data_o  output  32  register-file write data (registered)

## Operation
- Clock is clk. Reset rst_n is asynchronous and active-low.
- Reset clears FIFO (count 0), wait counter, scoreboard, rf_we_o, rf_sel_rd_o and rf_data_o. All outputs are 0 in reset, except mdu_ready_o, which is 1.
- FIFO enqueue: mdu_valid_i && mdu_ready_o. mdu_ready_o = (count < FIFO_DEPTH), computed from the registered count only. A dequeue in the same cycle gives no credit.
- Grant, evaluated each cycle from registered state:
  - FORCE: FIFO non-empty and wait_cnt == MAX_WAIT. FIFO head gets the port. wb_stall_o = wb_we_i.
  - WB: wb_we_i and not FORCE. Writeback gets the port. wb_stall_o = 0.
  - DRAIN: !wb_we_i and FIFO non-empty. FIFO head gets the port.
  - IDLE: otherwise. No write.
- wait_cnt:
  - Cleared on any dequeue or when the FIFO is empty.
  - Incremented while the FIFO is non-empty and the head is not granted.
  - Saturates at MAX_WAIT.
- Writes to x0 from either source present rf_we_o = 0. x0 FIFO entries still dequeue and consume the grant.
- Scoreboard:
  - issue_i with issue_rd_i ≠ 0 sets the bit.
  - Dequeue of the FIFO head clears the bit for its rd.
  - Set and clear of the same bit in the same cycle: set wins.
  - Bit 0 is always 0.
- Ordering of writes to a busy register is not checked here. Decode stalls on busy_o. A WB write to a busy rd is passed through unchanged.
- Simultaneous enqueue and dequeue keeps the count unchanged. FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Latency from grant to register-file write: 1 cycle. rf_* outputs are registered from the granted source in the cycle after the grant.
- MDU result: minimum 2 cycles from an accepted mdu_valid_i to rf_we_o (enqueue, then drain).
- The FIFO head reaches the port at most MAX_WAIT+1 cycles after it becomes head, under continuous wb_we_i.
- wb_stall_o is combinational from registered state and wb_we_i. It is high for exactly one cycle per forced drain.
- busy_o is registered. A set is visible the cycle after issue_i; a clear is visible the cycle after dequeue.
- Reset mid-operation: FIFO contents are discarded, the scoreboard is cleared, and no rf write follows the reset release until a new grant.

## Test plan
- Reset: assert rst_n=0 mid-traffic → rf_we_o=0, busy_o=0, mdu_ready_o=1, wb_stall_o=0 immediately; FIFO empty after release.
- WB only: wb_we_i=1, rd=5, data=0xDEADBEEF → next cycle rf_we_o=1, rf_sel_rd_o=5, rf_data_o=0xDEADBEEF; rd=0 → rf_we_o=0.
- MDU drain: issue rd=7 → busy_o[7]=1; mdu_valid_i with rd=7, data=0x12345678, no WB → rf write of 0x12345678 two cycles later, busy_o[7] cleared.
- Starvation: continuous wb_we_i, one MDU result queued → after 4 waiting cycles wb_stall_o=1 for one cycle, FIFO head written, then the held WB write completes.
- Backpressure: two MDU results with wb_we_i held and MAX_WAIT not yet reached → mdu_ready_o=0; third result held by the MDU until a dequeue, no data lost, order preserved.
- Scoreboard race: issue rd=9 in the same cycle the FIFO head with rd=9 dequeues → busy_o[9]=1 next cycle.
